// File: rtl/axis_i2s_transmitter_pkg.sv
// Shared constants, types and slot decode for the I2S transmit path.
// Also intended for reuse by a future I2S receiver.
package axis_i2s_transmitter_pkg;

   localparam int unsigned CNT_WIDTH      = 8;
   localparam int unsigned SLOTS_PER_CH   = 32;
   localparam int unsigned SCLK_DIV_LOG2  = 2;
   localparam int unsigned SLOT_WIDTH     = $clog2(SLOTS_PER_CH);
   localparam int unsigned MAX_DATA_WIDTH = SLOTS_PER_CH - 1;

   typedef enum logic {
      CH_LEFT  = 1'b0,
      CH_RIGHT = 1'b1
   } chan_e;

   typedef struct packed {
      chan_e                 ch;
      logic [SLOT_WIDTH-1:0] slot;
   } slot_pos_t;

   // Channel is the counter MSB; the slot is the bits between it and the SCLK divider.
   function automatic slot_pos_t decode_pos(input logic [CNT_WIDTH-1:0] cnt);
      slot_pos_t pos;
      pos.ch   = chan_e'(cnt[CNT_WIDTH-1]);
      pos.slot = cnt[CNT_WIDTH-2 -: SLOT_WIDTH];
      return pos;
   endfunction

endpackage

// File: rtl/axis_i2s_transmitter_if.sv
// AXI-Stream sample bus carrying stereo packets (left word, then right word with last).
interface axis_i2s_transmitter_if #(
   parameter int unsigned DATA_WIDTH = 24
) ();

   logic [DATA_WIDTH-1:0] data;
   logic                  valid;
   logic                  ready;
   logic                  last;

   modport master (
      output data,
      output valid,
      output last,
      input  ready
   );

   modport slave (
      input  data,
      input  valid,
      input  last,
      output ready
   );

endinterface

// File: rtl/axis_i2s_transmitter_timing.sv
// Free-running 256x frame counter with LRCK/SCLK generation and slot/wrap decode.
module i2s_tx_timing
   import axis_i2s_transmitter_pkg::*;
(
   input  logic      clk,
   input  logic      resetn,
   output logic      lrck,
   output logic      sclk,
   output logic      bit_edge_c,
   output logic      wrap_c,
   output slot_pos_t next_pos_c
);

   logic [CNT_WIDTH-1:0] cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_WIDTH'(1);
      end
   end

   assign lrck = cnt[CNT_WIDTH-1];
   assign sclk = cnt[SCLK_DIV_LOG2-1];

   // Next edge starts a new SCLK period / a new frame.
   assign bit_edge_c = &cnt[SCLK_DIV_LOG2-1:0];
   assign wrap_c     = &cnt;
   assign next_pos_c = decode_pos(cnt + CNT_WIDTH'(1));

endmodule

// File: rtl/axis_i2s_transmitter.sv
// AXI-Stream stereo packet to I2S line-out transmitter: holding buffer,
// per-frame active registers and MSB-first serializer with underrun flag.
module axis_i2s_transmitter
   import axis_i2s_transmitter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 24
) (
   input  logic                         clk,
   input  logic                         resetn,
   axis_i2s_transmitter_if.slave        s_axis,
   output logic                         tx_mclk,
   output logic                         tx_lrck,
   output logic                         tx_sclk,
   output logic                         tx_sdout,
   output logic                         underrun
);

   // One-bit delay after LRCK leaves room for at most SLOTS_PER_CH-1 data bits.
   if (DATA_WIDTH == 0 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
      $error("axis_i2s_transmitter: DATA_WIDTH must be 1..%0d", MAX_DATA_WIDTH);
   end

   logic      bit_edge_c;
   logic      wrap_c;
   slot_pos_t next_pos_c;

   i2s_tx_timing u_timing (
      .clk        (clk),
      .resetn     (resetn),
      .lrck       (tx_lrck),
      .sclk       (tx_sclk),
      .bit_edge_c (bit_edge_c),
      .wrap_c     (wrap_c),
      .next_pos_c (next_pos_c)
   );

   // MCLK is the system clock itself; the pad wrapper forwards it through an ODDR.
   assign tx_mclk = clk;

   logic                  ready_q;
   logic                  hold_full;
   logic [DATA_WIDTH-1:0] hold_l;
   logic [DATA_WIDTH-1:0] hold_r;
   logic [DATA_WIDTH-1:0] act_l;
   logic [DATA_WIDTH-1:0] act_r;

   logic                  hs_c;
   logic                  hold_full_nxt_c;

   assign s_axis.ready = ready_q;
   assign hs_c         = s_axis.valid && ready_q;

   // A right word fills the buffer; a frame load with a full buffer drains it.
   always_comb begin
      hold_full_nxt_c = hold_full;
      if (wrap_c && hold_full) begin
         hold_full_nxt_c = 1'b0;
      end
      if (hs_c && s_axis.last) begin
         hold_full_nxt_c = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ready_q   <= 1'b0;
         hold_full <= 1'b0;
         hold_l    <= '0;
         hold_r    <= '0;
      end else begin
         ready_q   <= ~hold_full_nxt_c;
         hold_full <= hold_full_nxt_c;
         if (hs_c && !s_axis.last) begin
            hold_l <= s_axis.data;
         end
         if (hs_c && s_axis.last) begin
            hold_r <= s_axis.data;
         end
      end
   end

   // Frame load: a missing packet plays silence and raises underrun for c=0.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         act_l    <= '0;
         act_r    <= '0;
         underrun <= 1'b0;
      end else begin
         underrun <= wrap_c && !hold_full;
         if (wrap_c) begin
            if (hold_full) begin
               act_l <= hold_l;
               act_r <= hold_r;
            end else begin
               act_l <= '0;
               act_r <= '0;
            end
         end
      end
   end

   logic [DATA_WIDTH-1:0]   sel_word_c;
   logic [SLOTS_PER_CH-1:0] slot_word_c;
   logic                    sdout_nxt_c;

   // Sample sits MSB-first in slots 1..DATA_WIDTH; slot 0 and the tail stay zero.
   always_comb begin
      sel_word_c  = (next_pos_c.ch == CH_RIGHT) ? act_r : act_l;
      slot_word_c = SLOTS_PER_CH'(sel_word_c) << (SLOTS_PER_CH - 1 - DATA_WIDTH);
      sdout_nxt_c = slot_word_c[SLOT_WIDTH'(SLOTS_PER_CH - 1) - next_pos_c.slot];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tx_sdout <= 1'b0;
      end else if (bit_edge_c) begin
         tx_sdout <= sdout_nxt_c;
      end
   end

endmodule

// File: tb/tb_axis_i2s_transmitter.sv
// Directed bench for axis_i2s_transmitter: frame table plus hand-written corner sequences.
module tb_axis_i2s_transmitter;

   localparam int unsigned DW = 24;

   logic clk = 1'b0;
   logic resetn;
   logic tx_mclk, tx_lrck, tx_sclk, tx_sdout, underrun;

   axis_i2s_transmitter_if #(.DATA_WIDTH(DW)) bus ();

   axis_i2s_transmitter #(.DATA_WIDTH(DW)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .s_axis   (bus),
      .tx_mclk  (tx_mclk),
      .tx_lrck  (tx_lrck),
      .tx_sclk  (tx_sclk),
      .tx_sdout (tx_sdout),
      .underrun (underrun)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int clk_err  = 0;
   int stray_ur = 0;

   // Reference frame position: c as the specification defines it.
   logic [7:0] bc;
   always @(posedge clk or negedge resetn) begin
      if (!resetn) bc <= 8'd0;
      else         bc <= bc + 8'd1;
   end

   typedef struct {
      logic [63:0] bits;
      logic        ur;
   } frame_t;

   frame_t      fq[$];
   logic [63:0] cur_bits;
   logic        cur_ur;
   bit          in_frame = 1'b0;

   // Capture each complete frame mid-bit (SCLK high), left slot 0 at bit 63.
   always @(negedge clk or negedge resetn) begin
      if (!resetn) begin
         in_frame = 1'b0;
      end else begin
         if (tx_lrck !== bc[7] || tx_sclk !== bc[1]) clk_err++;
         if (bc != 8'd0 && underrun !== 1'b0) stray_ur++;
         if (bc == 8'd0) begin
            in_frame = 1'b1;
            cur_bits = '0;
            cur_ur   = underrun;
         end
         if (in_frame && bc[1:0] == 2'd2) cur_bits[63 - int'(bc[7:2])] = tx_sdout;
         if (in_frame && bc == 8'd255) begin
            fq.push_back('{cur_bits, cur_ur});
            in_frame = 1'b0;
         end
      end
   end

   typedef struct {
      string          name;
      bit             send;
      logic [DW-1:0]  l;
      logic [DW-1:0]  r;
      logic           exp_ur;
      logic [DW-1:0]  exp_l;
      logic [DW-1:0]  exp_r;
   } frame_vec_t;

   frame_vec_t vecs [8];

   function automatic frame_vec_t mk(input string name, input bit send,
                                     input logic [DW-1:0] l, input logic [DW-1:0] r,
                                     input logic exp_ur,
                                     input logic [DW-1:0] el, input logic [DW-1:0] er);
      frame_vec_t v;
      v.name = name; v.send = send; v.l = l; v.r = r;
      v.exp_ur = exp_ur; v.exp_l = el; v.exp_r = er;
      return v;
   endfunction

   function automatic logic [63:0] exp_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
      logic [63:0] f;
      f = '0;
      for (int s = 1; s <= int'(DW); s++) begin
         f[63 - s] = l[int'(DW) - s];
         f[31 - s] = r[int'(DW) - s];
      end
      return f;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_word(input logic [DW-1:0] d, input logic last, input string name);
      bit   taken;
      logic was_ready;
      taken = 1'b0;
      bus.data  = d;
      bus.last  = last;
      bus.valid = 1'b1;
      for (int i = 0; i < 600 && !taken; i++) begin
         was_ready = bus.ready;
         @(posedge clk); #1;
         taken = (was_ready === 1'b1);
      end
      bus.valid = 1'b0;
      bus.last  = 1'b0;
      if (!taken) begin
         n_checks++; n_fail++;
         $display("FAIL %s: handshake timeout, ready never seen", name);
      end
   endtask

   task automatic pop_frame(input string name, input logic [DW-1:0] el,
                            input logic [DW-1:0] er, input logic eur);
      frame_t f;
      for (int i = 0; i < 700 && fq.size() == 0; i++) begin
         @(negedge clk); #1;
      end
      if (fq.size() == 0) begin
         n_checks++; n_fail++;
         $display("FAIL %s: no frame captured within bound", name);
      end else begin
         f = fq.pop_front();
         check({name, "_bits"}, f.bits, exp_frame(el, er));
         check({name, "_underrun"}, 64'(f.ur), 64'(eur));
      end
   endtask

   task automatic wait_bc(input logic [7:0] v);
      for (int i = 0; i < 300 && bc != v; i++) begin
         @(posedge clk); #1;
      end
      if (bc != v) begin
         n_checks++; n_fail++;
         $display("FAIL wait_bc: got c=%0d, expected %0d", bc, v);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_lrck"},     64'(tx_lrck),   64'd0);
      check({tag, "_sclk"},     64'(tx_sclk),   64'd0);
      check({tag, "_sdout"},    64'(tx_sdout),  64'd0);
      check({tag, "_underrun"}, 64'(underrun),  64'd0);
      check({tag, "_ready"},    64'(bus.ready), 64'd0);
   endtask

   initial begin
      vecs[0] = mk("f0_first_pkt", 1'b1, 24'h800001, 24'h7FFFFE, 1'b0, 24'h000000, 24'h000000);
      vecs[1] = mk("f1_play",      1'b0, 24'h000000, 24'h000000, 1'b0, 24'h800001, 24'h7FFFFE);
      vecs[2] = mk("f2_idle",      1'b0, 24'h000000, 24'h000000, 1'b1, 24'h000000, 24'h000000);
      vecs[3] = mk("f3_idle",      1'b0, 24'h000000, 24'h000000, 1'b1, 24'h000000, 24'h000000);
      vecs[4] = mk("f4_idle_send", 1'b1, 24'h123456, 24'hABCDEF, 1'b1, 24'h000000, 24'h000000);
      vecs[5] = mk("f5_play_send", 1'b1, 24'h000001, 24'hFFFFFF, 1'b0, 24'h123456, 24'hABCDEF);
      vecs[6] = mk("f6_play",      1'b0, 24'h000000, 24'h000000, 1'b0, 24'h000001, 24'hFFFFFF);
      vecs[7] = mk("f7_idle",      1'b0, 24'h000000, 24'h000000, 1'b1, 24'h000000, 24'h000000);

      resetn    = 1'b0;
      bus.valid = 1'b0;
      bus.last  = 1'b0;
      bus.data  = '0;

      repeat (10) @(posedge clk);
      #1;
      check_all_zero("reset");
      resetn = 1'b1;
      check("ready_at_release", 64'(bus.ready), 64'd0);
      for (int n = 1; n <= 128; n++) begin
         @(posedge clk); #1;
         if (n == 1)   check("ready_after_release", 64'(bus.ready), 64'd1);
         if (n == 127) check("lrck_low_clk127",     64'(tx_lrck),   64'd0);
         if (n == 128) check("lrck_rise_clk128",    64'(tx_lrck),   64'd1);
      end

      // Frame table: a packet sent during frame i is expected in frame i+1.
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].send) begin
            send_word(vecs[i].l, 1'b0, {vecs[i].name, "_l"});
            send_word(vecs[i].r, 1'b1, {vecs[i].name, "_r"});
         end
         pop_frame(vecs[i].name, vecs[i].exp_l, vecs[i].exp_r, vecs[i].exp_ur);
         wait_bc(8'd8);
      end

      // Back-to-back packets with a left-word overwrite; the second stalls to the wrap.
      send_word(24'h111111, 1'b0, "a_l0");
      send_word(24'hC00003, 1'b0, "a_l1");
      send_word(24'h3FFFFC, 1'b1, "a_r1");
      check("a_ready_low_after_pkt", 64'(bus.ready), 64'd0);
      send_word(24'h0F0F0F, 1'b0, "a_l2");
      check("a_l2_accept_after_wrap", 64'(bc), 64'd1);
      send_word(24'hF0F0F0, 1'b1, "a_r2");
      pop_frame("a_frame8",  24'h000000, 24'h000000, 1'b1);
      pop_frame("a_frame9",  24'hC00003, 24'h3FFFFC, 1'b0);
      pop_frame("a_frame10", 24'h0F0F0F, 24'hF0F0F0, 1'b0);
      wait_bc(8'd8);

      // Right-word handshake on the exact wrap edge.
      send_word(24'h00FF00, 1'b0, "b_l");
      wait_bc(8'd255);
      check("b_ready_before_wrap", 64'(bus.ready), 64'd1);
      bus.data  = 24'hFF00FF;
      bus.last  = 1'b1;
      bus.valid = 1'b1;
      @(posedge clk); #1;
      bus.valid = 1'b0;
      bus.last  = 1'b0;
      check("b_wrap_underrun", 64'(underrun),  64'd1);
      check("b_ready_low",     64'(bus.ready), 64'd0);
      check("b_at_c0",         64'(bc),        64'd0);
      pop_frame("b_frame11", 24'h000000, 24'h000000, 1'b1);
      pop_frame("b_frame12", 24'h000000, 24'h000000, 1'b1);
      pop_frame("b_frame13", 24'h00FF00, 24'hFF00FF, 1'b0);
      wait_bc(8'd8);

      // Asynchronous reset in the middle of a frame while a packet is held.
      send_word(24'hFFFFFF, 1'b0, "c_xl");
      send_word(24'h000001, 1'b1, "c_xr");
      pop_frame("c_frame14", 24'h000000, 24'h000000, 1'b1);
      wait_bc(8'd8);
      send_word(24'h5A5A5A, 1'b0, "c_yl");
      send_word(24'hA5A5A5, 1'b1, "c_yr");
      wait_bc(8'd42);
      check("c_sdout_slot10", 64'(tx_sdout), 64'd1);
      #2 resetn = 1'b0;
      #1;
      check_all_zero("c_midreset");
      repeat (3) @(posedge clk);
      #1;
      resetn = 1'b1;
      check("c_ready_at_release", 64'(bus.ready), 64'd0);
      @(posedge clk); #1;
      check("c_ready_after_release", 64'(bus.ready), 64'd1);
      pop_frame("c_post_frame0", 24'h000000, 24'h000000, 1'b0);
      pop_frame("c_post_frame1", 24'h000000, 24'h000000, 1'b1);

      check("lrck_sclk_track_counter", 64'(clk_err),  64'd0);
      check("underrun_only_at_c0",     64'(stray_ur), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
